// File: rtl/issue_ctrl.sv
// Dual-issue hazard controller: issues a decoded instruction pair, splits dependent
// pairs across two cycles, stalls on load-use hits and flushes decode on taken jumps.
module issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pair_valid,
  input  logic        dependency,
  input  logic        jumpE1,
  input  logic        jumpE2,
  input  logic [3:0]  MemtoRegE1,
  input  logic [3:0]  MemtoRegE2,
  input  logic        RegWriteE1,
  input  logic        RegWriteE2,
  input  logic [4:0]  writeregE1,
  input  logic [4:0]  writeregE2,
  input  logic [4:0]  RsD1,
  input  logic [4:0]  RtD1,
  input  logic [4:0]  RsD2,
  input  logic [4:0]  RtD2,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        issue1,
  output logic        issue2,
  output logic        split,
  output logic [15:0] stall_cnt
);

  typedef enum logic {NORMAL = 1'b0, SPLIT = 1'b1} stateT;

  stateT       stateReg;
  stateT       stateNext;
  logic [15:0] stallCntReg;
  logic        luse1;
  logic        luse2;
  logic        jumpE;

  // Register r is produced by a load still sitting in E (r0 never counts).
  function automatic logic ldHit(input logic [4:0] r);
    logic hit1;
    logic hit2;
    hit1 = (MemtoRegE1 != 4'd0) && RegWriteE1 && (writeregE1 == r);
    hit2 = (MemtoRegE2 != 4'd0) && RegWriteE2 && (writeregE2 == r);
    return (r != 5'd0) && (hit1 || hit2);
  endfunction

  assign luse1 = ldHit(RsD1) | ldHit(RtD1);
  assign luse2 = ldHit(RsD2) | ldHit(RtD2);
  assign jumpE = jumpE1 | jumpE2;

  always_comb begin
    stateNext = stateReg;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    issue1    = 1'b0;
    issue2    = 1'b0;
    if (jumpE) begin
      flushD    = 1'b1;
      stateNext = NORMAL;
    end else begin
      case (stateReg)
        NORMAL: begin
          if (pair_valid) begin
            if (luse1 || luse2) begin
              stallF = 1'b1;
              stallD = 1'b1;
              flushE = 1'b1;
            end else if (dependency) begin
              // Slot1 goes now; the pair is held so slot2 can follow next cycle.
              issue1    = 1'b1;
              stallF    = 1'b1;
              stallD    = 1'b1;
              stateNext = SPLIT;
            end else begin
              issue1 = 1'b1;
              issue2 = 1'b1;
            end
          end
        end
        SPLIT: begin
          // Slot1 already left, so only slot2's sources can cause a load-use stall.
          if (luse2) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end else begin
            issue2    = 1'b1;
            stateNext = NORMAL;
          end
        end
        default: stateNext = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= NORMAL;
      stallCntReg <= 16'd0;
    end else begin
      stateReg <= stateNext;
      if (stallD && (stallCntReg != 16'hFFFF))
        stallCntReg <= stallCntReg + 16'd1;
    end
  end

  assign split     = (stateReg == SPLIT);
  assign stall_cnt = stallCntReg;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: one linear stimulus sequence with hand-computed
// expectations checked by immediate assertions.
module tb_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pair_valid;
  logic        dependency;
  logic        jumpE1;
  logic        jumpE2;
  logic [3:0]  MemtoRegE1;
  logic [3:0]  MemtoRegE2;
  logic        RegWriteE1;
  logic        RegWriteE2;
  logic [4:0]  writeregE1;
  logic [4:0]  writeregE2;
  logic [4:0]  RsD1;
  logic [4:0]  RtD1;
  logic [4:0]  RsD2;
  logic [4:0]  RtD2;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        flushE;
  logic        issue1;
  logic        issue2;
  logic        split;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pair_valid (pair_valid),
    .dependency (dependency),
    .jumpE1     (jumpE1),
    .jumpE2     (jumpE2),
    .MemtoRegE1 (MemtoRegE1),
    .MemtoRegE2 (MemtoRegE2),
    .RegWriteE1 (RegWriteE1),
    .RegWriteE2 (RegWriteE2),
    .writeregE1 (writeregE1),
    .writeregE2 (writeregE2),
    .RsD1       (RsD1),
    .RtD1       (RtD1),
    .RsD2       (RsD2),
    .RtD2       (RtD2),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .flushE     (flushE),
    .issue1     (issue1),
    .issue2     (issue2),
    .split      (split),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed view of the control outputs: {stallF, stallD, flushD, flushE, issue1, issue2}.
  task automatic chkCtl(input string tag, input logic [5:0] exp);
    chk(tag, {10'd0, stallF, stallD, flushD, flushE, issue1, issue2}, {10'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clearIn;
    pair_valid = 1'b0;
    dependency = 1'b0;
    jumpE1     = 1'b0;
    jumpE2     = 1'b0;
    MemtoRegE1 = 4'd0;
    MemtoRegE2 = 4'd0;
    RegWriteE1 = 1'b0;
    RegWriteE2 = 1'b0;
    writeregE1 = 5'd0;
    writeregE2 = 5'd0;
    RsD1       = 5'd1;
    RtD1       = 5'd2;
    RsD2       = 5'd3;
    RtD2       = 5'd4;
  endtask

  initial begin
    clearIn();
    rst_n = 1'b0;
    settle();
    chkCtl("reset_ctl", 6'b000000);
    chk("reset_split", {15'd0, split}, 16'd0);
    chk("reset_cnt", stall_cnt, 16'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // Independent pair: dual issue, no stall.
    pair_valid = 1'b1;
    RsD1 = 5'd5; RtD1 = 5'd6; RsD2 = 5'd7; RtD2 = 5'd9;
    settle();
    chkCtl("dual_issue", 6'b000011);
    tick();
    chk("dual_split", {15'd0, split}, 16'd0);
    chk("dual_cnt", stall_cnt, 16'd0);

    // Dependent pair: slot1 then slot2.
    dependency = 1'b1;
    settle();
    chkCtl("dep_c0", 6'b110010);
    chk("dep_c0_split", {15'd0, split}, 16'd0);
    tick();
    chkCtl("dep_c1", 6'b000001);
    chk("dep_c1_split", {15'd0, split}, 16'd1);
    chk("dep_c1_cnt", stall_cnt, 16'd1);
    tick();
    clearIn();
    settle();
    chk("dep_c2_split", {15'd0, split}, 16'd0);
    chk("dep_c2_cnt", stall_cnt, 16'd1);
    chkCtl("idle", 6'b000000);

    // Load in E1 feeding slot2 source.
    pair_valid = 1'b1;
    MemtoRegE1 = 4'h1; RegWriteE1 = 1'b1; writeregE1 = 5'd8; RsD2 = 5'd8;
    settle();
    chkCtl("luse_e1", 6'b110100);
    tick();
    chk("luse_e1_cnt", stall_cnt, 16'd2);
    chk("luse_e1_split", {15'd0, split}, 16'd0);
    writeregE1 = 5'd0; RsD2 = 5'd0;
    settle();
    chkCtl("luse_r0", 6'b000011);
    writeregE1 = 5'd8; RsD2 = 5'd8; MemtoRegE1 = 4'h0;
    settle();
    chkCtl("luse_noload", 6'b000011);
    MemtoRegE1 = 4'h1; RegWriteE1 = 1'b0;
    settle();
    chkCtl("luse_nowrite", 6'b000011);

    // Load in E2 feeding slot1 Rt; load-use beats the dependency split.
    clearIn();
    pair_valid = 1'b1; dependency = 1'b1;
    MemtoRegE2 = 4'h8; RegWriteE2 = 1'b1; writeregE2 = 5'd3; RtD1 = 5'd3; RsD2 = 5'd10;
    settle();
    chkCtl("luse_e2", 6'b110100);
    tick();
    chk("luse_e2_cnt", stall_cnt, 16'd3);
    chk("luse_e2_split", {15'd0, split}, 16'd0);

    // In SPLIT a slot1-only hit is ignored.
    clearIn();
    pair_valid = 1'b1; dependency = 1'b1;
    tick();
    chk("split1_enter", {15'd0, split}, 16'd1);
    MemtoRegE1 = 4'h2; RegWriteE1 = 1'b1; writeregE1 = 5'd1;
    settle();
    chkCtl("split_luse1_ign", 6'b000001);
    tick();
    chk("split1_exit", {15'd0, split}, 16'd0);
    chk("split1_cnt", stall_cnt, 16'd4);

    // In SPLIT a slot2 hit stalls, then a jump overrides it.
    clearIn();
    pair_valid = 1'b1; dependency = 1'b1;
    tick();
    MemtoRegE1 = 4'h4; RegWriteE1 = 1'b1; writeregE1 = 5'd4;
    settle();
    chkCtl("split_luse2", 6'b110100);
    tick();
    chk("split_luse2_hold", {15'd0, split}, 16'd1);
    chk("split_luse2_cnt", stall_cnt, 16'd6);
    jumpE2 = 1'b1;
    settle();
    chkCtl("split_jump", 6'b001000);
    tick();
    chk("split_jump_exit", {15'd0, split}, 16'd0);
    chk("split_jump_cnt", stall_cnt, 16'd6);

    // Jump in NORMAL beats load-use and dependency.
    jumpE2 = 1'b0; jumpE1 = 1'b1; RsD1 = 5'd4;
    settle();
    chkCtl("normal_jump", 6'b001000);
    tick();
    chk("normal_jump_state", {15'd0, split}, 16'd0);
    chk("normal_jump_cnt", stall_cnt, 16'd6);

    // Asynchronous reset while in SPLIT.
    clearIn();
    pair_valid = 1'b1; dependency = 1'b1;
    tick();
    chk("pre_rst_split", {15'd0, split}, 16'd1);
    chk("pre_rst_cnt", stall_cnt, 16'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_split", {15'd0, split}, 16'd0);
    chk("async_rst_cnt", stall_cnt, 16'd0);
    rst_n = 1'b1;
    pair_valid = 1'b0; dependency = 1'b0;
    settle();
    chkCtl("post_rst_no_issue2", 6'b000000);
    tick();
    chk("post_rst_state", {15'd0, split}, 16'd0);
    chkCtl("post_rst_idle", 6'b000000);

    // First edge after another reset release evaluates normally.
    rst_n = 1'b0;
    #1;
    pair_valid = 1'b1; dependency = 1'b1;
    rst_n = 1'b1;
    settle();
    chkCtl("rel_dep_c0", 6'b110010);
    tick();
    chk("rel_first_edge", {15'd0, split}, 16'd1);
    chk("rel_first_cnt", stall_cnt, 16'd1);

    // Counter saturation under a persistent load-use hit.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    clearIn();
    pair_valid = 1'b1;
    MemtoRegE1 = 4'h1; RegWriteE1 = 1'b1; writeregE1 = 5'd7; RsD2 = 5'd7;
    settle();
    chk("sat_start", stall_cnt, 16'd0);
    chkCtl("sat_stall", 6'b110100);
    repeat (65534) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (10) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chkCtl("sat_still_stall", 6'b110100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have inputs: pair_valid 1 (D holds a fetched pair); dependency 1 (intra-pair RAW/WAW, slot2 on slot1); jumpE1, jumpE2 1 each (taken jump resolving in E).
REQ-003 SHALL have inputs: MemtoRegE1, MemtoRegE2 4 each (nonzero = load in E); RegWriteE1, RegWriteE2 1 each; writeregE1, writeregE2 5 each.
REQ-004 SHALL have inputs: RsD1, RtD1, RsD2, RtD2 5 each (decode source registers).
REQ-005 SHALL have outputs: stallF, stallD 1 (hold F/D registers); flushD 1 (clear D register); flushE 1 (insert bubble into E).
REQ-006 SHALL have outputs: issue1, issue2 1 (slot qualifiers; deasserted slot enters E with all control signals zeroed); split 1 (FSM in SPLIT); stall_cnt 16 (performance counter).

Function
REQ-007 SHALL implement a two-state FSM: NORMAL, SPLIT; state and stall_cnt are the only registers; all other outputs are combinational from state and inputs.
REQ-008 SHALL compute ldhit(r) = 1 when r != 0 and, for some k in {1,2}, MemtoRegEk != 0 and RegWriteEk = 1 and writeregEk = r.
REQ-009 SHALL compute luse1 = ldhit(RsD1) | ldhit(RtD1); luse2 = ldhit(RsD2) | ldhit(RtD2).
REQ-010 SHALL apply priority per cycle: jump > load-use > dependency split > normal issue.
REQ-011 Jump (jumpE1 | jumpE2), either state: flushD=1, issue1=issue2=0, stallF=stallD=0, flushE=0; next state NORMAL.
REQ-012 NORMAL, pair_valid=0, no jump: issue1=issue2=0, no stall, no flush; stay NORMAL.
REQ-013 NORMAL, pair_valid=1, luse1|luse2: stallF=stallD=1, flushE=1, issue1=issue2=0; stay NORMAL.
REQ-014 NORMAL, pair_valid=1, no load-use, dependency=1: issue1=1, issue2=0, stallF=stallD=1; next SPLIT.
REQ-015 NORMAL, pair_valid=1, no load-use, dependency=0: issue1=issue2=1, no stall; stay NORMAL.
REQ-016 SPLIT, no jump, luse2=1: stallF=stallD=1, flushE=1, issue1=issue2=0; stay SPLIT.
REQ-017 SPLIT, no jump, luse2=0: issue1=0, issue2=1, no stall; next NORMAL (slot1 never reissued; luse1 ignored in SPLIT).
REQ-018 flushE SHALL equal 1 exactly when stallD=1 and issue1=issue2=0; never asserted together with flushD.
REQ-019 split SHALL equal 1 iff state = SPLIT.
REQ-020 stall_cnt SHALL increment by 1 on each rising edge where stallD=1, saturating at 16'hFFFF (no wrap).
REQ-021 A dependent pair SHALL issue across exactly two cycles absent load-use/jump; a load-use stall SHALL last while the hit persists (one cycle with M forwarding).

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=NORMAL and stall_cnt=0; outputs then follow REQ-012..015 combinationally.
REQ-023 Reset asserted in SPLIT SHALL abandon the pending slot2; no issue2 after rst_n returns high unless a new pair is decoded.
REQ-024 First rising edge after rst_n deassertion SHALL be a normal evaluation edge.

Verification
REQ-025 pair_valid=1, dependency=0, no loads in E -> issue1=issue2=1, stallF=stallD=0, state stays NORMAL, stall_cnt=0.
REQ-026 dependency=1 for one pair -> cycle0: issue1=1, issue2=0, stallD=1, split=0; cycle1: issue1=0, issue2=1, split=1; cycle2: NORMAL, stall_cnt=1.
REQ-027 MemtoRegE1=4'h1, RegWriteE1=1, writeregE1=5'd8, RsD2=5'd8 -> stallF=stallD=flushE=1, issue1=issue2=0; same with writeregE1=0 and RsD2=0 -> no stall.
REQ-028 In SPLIT with jumpE2=1 and luse2=1 -> flushD=1, flushE=0, stallD=0, next NORMAL.
REQ-029 Hold stallD=1 for 70000 cycles -> stall_cnt reaches 16'hFFFF and remains there.
REQ-030 Pulse rst_n low mid-cycle while in SPLIT with stall_cnt=5 -> split=0 and stall_cnt=0 immediately, before next clk edge.
